sha256_host_ctrl: RTL
=====================

# sha256_host_ctrl

Host-side controller for the SHA-256 engine's memory and start/done interface. It accepts a message as a 32-bit valid/ready word stream, writes it into the shared word-addressed memory, starts the engine, waits for completion, reads back the eight hash words and emits them as a 32-bit output stream. It sits between the host stream fabric, the single-port synchronous memory and the SHA-256 engine, and owns the memory-port mux between host and engine.

## Interface
- NUM_OF_WORDS, 20: message length in 32-bit words (1..255).
- MSG_ADDR, 16'h0000: word address where the message is written; driven on sha_message_addr.
- OUT_ADDR, 16'h0100: word address the engine writes the hash to; driven on sha_output_addr.
- TIMEOUT_CYCLES, 4096: watchdog limit; used only with SHA_HOST_TIMEOUT_EN.

Ports:
- clk  in  1  clock; memory and engine share it.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  message word valid.
- in_ready  out  1  controller accepts a message word.
- in_data  in  32  message word.
- out_valid  out  1  hash word valid.
- out_ready  in  1  consumer accepts a hash word.
- out_data  out  32  hash word, h0 first.
- out_last  out  1  high with the 8th hash word.
- busy  out  1  high in every state except S_LOAD.
- err  out  1  sticky timeout flag.
- sha_start  out  1  one-cycle start pulse to the engine.
- sha_done  in  1  engine done; high whenever the engine is idle.
- sha_message_addr  out  16  constant MSG_ADDR.
- sha_output_addr  out  16  constant OUT_ADDR.
- sha_mem_we  in  1  engine memory request: write enable.
- sha_mem_addr  in  16  engine memory request: address.
- sha_mem_write_data  in  32  engine memory request: write data.
- sha_mem_read_data  out  32  memory read data forwarded to the engine.
- mem_we  out  1  memory port write enable.
- mem_addr  out  16  memory port address.
- mem_write_data  out  32  memory port write data.
- mem_read_data  in  32  memory read data, valid one cycle after the address.

## Operation
- Reset values:
  - state S_LOAD.
  - All counters 0.
  - in_ready=1, out_valid=0, out_last=0, out_data=0.
  - sha_start=0, err=0, mem_we=0, mem_addr=MSG_ADDR, mem_write_data=0.
- Memory mux:
  - Engine owns the port (mem_* = sha_mem_*) in S_START, S_WAIT_LO and S_WAIT_HI.
  - The controller owns it in all other states.
  - sha_mem_read_data = mem_read_data at all times.
- S_LOAD:
  - in_ready=1.
  - Each in_valid&in_ready handshake drives mem_we=1, mem_addr=MSG_ADDR+wcnt, mem_write_data=in_data in the same cycle (combinational), then increments wcnt.
  - On the handshake with wcnt==NUM_OF_WORDS-1, in_ready drops in the next cycle and the state goes to S_START.
- S_START: sha_start=1 for exactly one cycle; go to S_WAIT_LO.
- S_WAIT_LO: wait for sha_done==0; then S_WAIT_HI. A done that never falls is covered only by the watchdog.
- S_WAIT_HI: wait for sha_done==1; then S_RD_REQ with k=0.
- S_RD_REQ: mem_addr=OUT_ADDR+k, mem_we=0; go to S_RD_CAP.
- S_RD_CAP: latch mem_read_data into out_data, set out_valid=1 and out_last=(k==7); go to S_OUT.
- S_OUT:
  - Hold out_data, out_valid and out_last stable until out_ready.
  - On the handshake: if k==7, clear wcnt and go to S_LOAD; else k++ and go to S_RD_REQ.
- Address arithmetic is 16-bit, modulo 2^16; base+offset wraps silently.
- sha_done is ignored in every state except S_WAIT_LO and S_WAIT_HI.
- Reset asserted mid-operation returns everything to reset values immediately. No partial hash word is emitted after reset.

## Timing
- Word write occurs in the cycle of the input handshake; throughput is 1 word/cycle.
- sha_start is asserted the cycle after the last message handshake.
- First out_valid appears 2 cycles after sha_done is sampled high in S_WAIT_HI.
- Each hash word costs 3 cycles minimum (REQ, CAP, OUT) with out_ready held high: 24 cycles for the full hash.
- out_valid never drops without a handshake.

## Configuration
- SHA_HOST_TIMEOUT_EN defined:
  - A 32-bit counter runs in S_WAIT_LO and S_WAIT_HI.
  - When it reaches TIMEOUT_CYCLES, err is set (sticky until reset), the state goes to S_LOAD with wcnt=0, and no output is produced.
  - The counter clears on entry to S_START.
- SHA_HOST_TIMEOUT_EN not defined: no counter exists, err is tied 0, and the controller waits indefinitely.

## Structure
- Shared package sha256_pkg:
  - state enum typedef (S_LOAD, S_START, S_WAIT_LO, S_WAIT_HI, S_RD_REQ, S_RD_CAP, S_OUT).
  - HASH_WORDS=8.
  - address and word width constants.
- One sub-module: sha_mem_mux, the combinational memory-port select between host and engine, reusable by other memory clients.

## Test plan
- Load words 32'h00000001..32'h00000014 with in_valid held high -> memory 0x0000..0x0013 holds them; sha_start is high exactly one cycle, the cycle after the 20th handshake.
- Engine stub drops done for 50 cycles and writes 32'hA0000000+n to 0x0100+n -> out stream is A0000000..A0000007, out_last only on the 8th word, busy falls after it.
- out_ready held low for 3 cycles on word 2 -> out_data stays A0000002, out_valid stays high, no memory read is issued.
- in_valid toggled every other cycle -> exactly 20 writes, at consecutive addresses, with no gaps in the address sequence.
- With SHA_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=100, stub never raises done -> err=1 at cycle 100 of waiting, state S_LOAD, in_ready=1, no out_valid.
- reset_n pulsed low during S_WAIT_HI -> all outputs at reset values; a new 20-word load completes normally.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 host controller and its memory clients.
package sha256_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned HASH_WORDS = 8;

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_RD_REQ,
        S_RD_CAP,
        S_OUT
    } state_e;

    // Word address of base+offset; wraps modulo 2^16 by construction.
    function automatic logic [ADDR_W-1:0] addr_offset(input logic [ADDR_W-1:0] base,
                                                      input logic [7:0]        off);
        return base + {{(ADDR_W - 8){1'b0}}, off};
    endfunction

endpackage

// File: rtl/sha_mem_mux.sv
// Combinational select of one single-port memory between a host client and the engine.
// Read data is fanned out unconditionally; only the request side is muxed.
module sha_mem_mux
    import sha256_pkg::*;
(
    input  logic              eng_sel,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [WORD_W-1:0] host_write_data,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [WORD_W-1:0] eng_write_data,
    output logic [WORD_W-1:0] eng_read_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_write_data,
    input  logic [WORD_W-1:0] mem_read_data
);

    // Route the request of whichever client currently owns the port.
    always_comb begin
        if (eng_sel) begin
            mem_we         = eng_we;
            mem_addr       = eng_addr;
            mem_write_data = eng_write_data;
        end else begin
            mem_we         = host_we;
            mem_addr       = host_addr;
            mem_write_data = host_write_data;
        end
    end

    assign eng_read_data = mem_read_data;

endmodule

// File: rtl/sha256_host_ctrl.sv
// Host-side controller for the SHA-256 engine: streams a message into shared memory,
// kicks the engine, waits for done and streams the eight hash words back out.
// Optional build macro SHA_HOST_TIMEOUT_EN adds a watchdog on the engine wait states
// with a sticky err flag; without it err is tied low and the wait is unbounded.
module sha256_host_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned       NUM_OF_WORDS   = 20,
    parameter logic [ADDR_W-1:0] MSG_ADDR       = 16'h0000,
    parameter logic [ADDR_W-1:0] OUT_ADDR       = 16'h0100,
    parameter int unsigned       TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err,
    output logic              sha_start,
    input  logic              sha_done,
    output logic [ADDR_W-1:0] sha_message_addr,
    output logic [ADDR_W-1:0] sha_output_addr,
    input  logic              sha_mem_we,
    input  logic [ADDR_W-1:0] sha_mem_addr,
    input  logic [WORD_W-1:0] sha_mem_write_data,
    output logic [WORD_W-1:0] sha_mem_read_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_write_data,
    input  logic [WORD_W-1:0] mem_read_data
);

    localparam logic [7:0] LAST_WORD = 8'(NUM_OF_WORDS - 1);
    localparam logic [2:0] LAST_HASH = 3'(HASH_WORDS - 1);

    state_e            state_q;
    logic [7:0]        wcnt_q;
    logic [2:0]        k_q;
    logic [WORD_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              sha_start_q;

    logic              eng_sel;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [WORD_W-1:0] host_write_data;

`ifdef SHA_HOST_TIMEOUT_EN
    logic [31:0]       timer_q;
    logic              err_q;
`endif

    assign in_ready         = (state_q == S_LOAD);
    assign busy             = (state_q != S_LOAD);
    assign out_valid        = out_valid_q;
    assign out_data         = out_data_q;
    assign out_last         = out_last_q;
    assign sha_start        = sha_start_q;
    assign sha_message_addr = MSG_ADDR;
    assign sha_output_addr  = OUT_ADDR;
    assign eng_sel          = (state_q == S_START) || (state_q == S_WAIT_LO) ||
                              (state_q == S_WAIT_HI);

`ifdef SHA_HOST_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Host-side memory request: message writes while loading, hash reads afterwards.
    always_comb begin
        host_we         = 1'b0;
        host_addr       = addr_offset(MSG_ADDR, wcnt_q);
        host_write_data = '0;
        case (state_q)
            S_LOAD: begin
                host_we         = in_valid;
                host_write_data = in_valid ? in_data : '0;
            end
            S_RD_REQ, S_RD_CAP, S_OUT: begin
                host_addr = addr_offset(OUT_ADDR, {5'd0, k_q});
            end
            default: ;
        endcase
    end

    sha_mem_mux u_mem_mux (
        .eng_sel         (eng_sel),
        .host_we         (host_we),
        .host_addr       (host_addr),
        .host_write_data (host_write_data),
        .eng_we          (sha_mem_we),
        .eng_addr        (sha_mem_addr),
        .eng_write_data  (sha_mem_write_data),
        .eng_read_data   (sha_mem_read_data),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data)
    );

    // Control FSM with registered stream and start outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_LOAD;
            wcnt_q      <= '0;
            k_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sha_start_q <= 1'b0;
`ifdef SHA_HOST_TIMEOUT_EN
            timer_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            sha_start_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        wcnt_q <= wcnt_q + 8'd1;
                        if (wcnt_q == LAST_WORD) begin
                            state_q     <= S_START;
                            sha_start_q <= 1'b1;
`ifdef SHA_HOST_TIMEOUT_EN
                            timer_q     <= '0;
`endif
                        end
                    end
                end
                S_START: state_q <= S_WAIT_LO;
                S_WAIT_LO: begin
                    if (!sha_done) state_q <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (sha_done) begin
                        state_q <= S_RD_REQ;
                        k_q     <= '0;
                    end
                end
                S_RD_REQ: state_q <= S_RD_CAP;
                S_RD_CAP: begin
                    // Memory returns the word addressed during S_RD_REQ.
                    out_data_q  <= mem_read_data;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (k_q == LAST_HASH);
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (k_q == LAST_HASH) begin
                            wcnt_q  <= '0;
                            state_q <= S_LOAD;
                        end else begin
                            k_q     <= k_q + 3'd1;
                            state_q <= S_RD_REQ;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
`ifdef SHA_HOST_TIMEOUT_EN
            // Watchdog overrides any wait-state transition taken this cycle.
            if ((state_q == S_WAIT_LO) || (state_q == S_WAIT_HI)) begin
                if (timer_q == TIMEOUT_CYCLES - 1) begin
                    err_q   <= 1'b1;
                    state_q <= S_LOAD;
                    wcnt_q  <= '0;
                end else begin
                    timer_q <= timer_q + 32'd1;
                end
            end
`endif
        end
    end

endmodule
